dma_engineer: RTL and testbench
===============================

# dma_engineer

Responder end of the per-layer weight-fetch DMA protocol. It accepts a `dma_engineer_req` with a start address and length from one layer controller, issues in-order 512-bit beat reads to the external memory read port, and streams the returned beats back as `dma_engineer_dout` qualified by `dma_engineer_dout_en`, with `dma_engineer_dout_eop` on the last beat. One instance serves one layer; the layer's weight double buffer consumes the stream without backpressure.

## Interface

Parameters:

- `ADDR_W`, 27, beat-address width; `start_addr` and `length` are in 512-bit beats.
- `DATA_W`, 512, beat width.
- `MAX_OUT`, 16, maximum reads in flight (power of two, ≥2).

Ports:

- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dma_engineer_req`  in  1  level request; held until ack.
- `dma_engineer_ack`  out  1  one-cycle accept pulse.
- `dma_engineer_start_addr`  in  ADDR_W  first beat address; sampled with ack.
- `dma_engineer_length`  in  ADDR_W  beat count; sampled with ack.
- `dma_engineer_dout`  out  DATA_W  returned beat.
- `dma_engineer_dout_en`  out  1  `dout` valid this cycle.
- `dma_engineer_dout_eop`  out  1  last beat of transfer; coincides with `dout_en`.
- `mem_rd_en`  out  1  read command valid.
- `mem_rd_addr`  out  ADDR_W  read beat address.
- `mem_rd_rdy`  in  1  memory accepts command this cycle.
- `mem_rd_data_valid`  in  1  read data return, in issue order, latency ≥1.
- `mem_rd_data`  in  DATA_W  read data.
- `busy`  out  1  high from ack until the cycle after eop.
- `err_zero_len`  out  1  one-cycle pulse on accepting `length == 0`.

## Operation

- States: IDLE, ISSUE, DRAIN.
- IDLE, `req = 1` sampled: register `ack = 1` for one cycle and latch `start_addr` into `cur_addr` and `length` into `len`.
  - `len == 0`: pulse `err_zero_len` with ack. No reads, no dout, no eop. Stay in IDLE, but ignore `req` for the cycle following ack.
  - Otherwise: go to ISSUE and set `busy`.
- ISSUE: `mem_rd_en = (issued < len) && (outstanding < MAX_OUT)`, combinational.
  - `mem_rd_addr = cur_addr`.
  - On `mem_rd_en && mem_rd_rdy`: `cur_addr++` (wraps mod 2^ADDR_W), `issued++`.
  - When `issued == len` after an accept, go to DRAIN.
- `outstanding` is +1 on accept and −1 on `mem_rd_data_valid`; both in the same cycle leave it unchanged.
- Data path, registered: `dout <= mem_rd_data`, `dout_en <= mem_rd_data_valid`, `dout_eop <= mem_rd_data_valid && (returned == len-1)`. `returned` counts valids.
  - Data can return while still in ISSUE.
- DRAIN: when the last valid is registered, go to IDLE; `busy` drops the next cycle.
- `req` is ignored in ISSUE/DRAIN. The requester must drop `req` the cycle after ack.
- `mem_rd_data_valid` outside a transfer, or beyond `len`, is a protocol violation. It is dropped (no dout_en), with no state change.
- `dout` holds its last value when `dout_en = 0`.
- Counters are ADDR_W+1 bits wide so `len = 2^ADDR_W−1` does not overflow.

## Timing

- Reset: all outputs 0, state IDLE, counters 0, `dout` 0. Reset mid-transfer aborts immediately: no eop, and late memory returns are dropped. The memory side must also be reset.
- req→ack: 1 cycle (req sampled at edge k, ack high during k+1).
- ack→first `mem_rd_en`: 0 cycles (asserted in the ack cycle).
- `mem_rd_data_valid`→`dout_en`: 1 cycle.
- Throughput: 1 beat/cycle when `mem_rd_rdy = 1` and memory latency < MAX_OUT.
- Earliest next ack: the cycle after `dout_eop` if `req` is high.

## Test plan

- Basic: req with addr=1312, len=8, `mem_rd_rdy = 1`, latency 3.
  - ack at cycle 1; reads to 1312..1319 on consecutive cycles.
  - 8 `dout_en` beats match memory contents; eop only on the 8th; `busy` falls one cycle after eop.
- Backpressure: `mem_rd_rdy` toggling 1,0,0,1… with len=5.
  - Exactly 5 accepted reads at consecutive addresses, no duplicates; 5 beats, one eop.
- Outstanding cap: MAX_OUT=4, latency 10, len=12.
  - `mem_rd_en` deasserts with 4 in flight; all 12 beats in order; eop on beat 12.
- Zero length and wrap:
  - len=0: ack plus `err_zero_len`, no reads, no dout.
  - addr=2^27−2, len=4: addresses 2^27−2, 2^27−1, 0, 1.
- Back-to-back: second req held high during the first transfer (len=2).
  - Second ack exactly one cycle after the first eop; second transfer correct.
- Reset mid-transfer: assert `rst` after 3 of 8 beats.
  - All outputs 0 next cycle; no eop; a new req after reset completes normally.

Source files
------------

// File: rtl/dma_engineer.sv
// dma_engineer: weight-fetch DMA responder issuing in-order beat reads and streaming returned beats
module dma_engineer #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 512,
  parameter int MAX_OUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_engineer_req,
  output logic              dma_engineer_ack,
  input  logic [ADDR_W-1:0] dma_engineer_start_addr,
  input  logic [ADDR_W-1:0] dma_engineer_length,
  output logic [DATA_W-1:0] dma_engineer_dout,
  output logic              dma_engineer_dout_en,
  output logic              dma_engineer_dout_eop,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_rdy,
  input  logic              mem_rd_data_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              err_zero_len
);
  localparam int CW = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CW-1:0] len_q, len_d, issued_q, issued_d, returned_q, returned_d, outstanding;
  logic ack_q, ack_d, err_q, err_d, dout_en_q, dout_en_d, eop_q, eop_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic take, accept, ret;
  assign outstanding = issued_q - returned_q;
  assign take = state_q == IDLE && dma_engineer_req && !ack_q;
  assign mem_rd_en = state_q == ISSUE && issued_q < len_q && outstanding < CW'(MAX_OUT);
  assign accept = mem_rd_en && mem_rd_rdy;
  assign ret = mem_rd_data_valid && state_q != IDLE && returned_q < issued_q;
  assign mem_rd_addr = cur_addr_q;
  assign dma_engineer_ack = ack_q;
  assign err_zero_len = err_q;
  assign dma_engineer_dout = dout_q;
  assign dma_engineer_dout_en = dout_en_q;
  assign dma_engineer_dout_eop = eop_q;
  assign busy = state_q != IDLE || eop_q;
  // next state: accept a request, count issued/returned beats, flag the last beat
  always_comb begin
    state_d = state_q;
    cur_addr_d = cur_addr_q;
    len_d = len_q;
    issued_d = issued_q;
    returned_d = ret ? returned_q + 1'b1 : returned_q;
    ack_d = take;
    err_d = take && dma_engineer_length == '0;
    dout_en_d = ret;
    eop_d = ret && returned_q == len_q - 1'b1;
    dout_d = ret ? mem_rd_data : dout_q;
    if (take) begin
      cur_addr_d = dma_engineer_start_addr;
      len_d = {1'b0, dma_engineer_length};
      issued_d = '0;
      returned_d = '0;
      state_d = dma_engineer_length == '0 ? IDLE : ISSUE;
    end
    if (accept) begin
      cur_addr_d = cur_addr_q + 1'b1;
      issued_d = issued_q + 1'b1;
      state_d = issued_d == len_q ? DRAIN : ISSUE;
    end
    if (state_q == DRAIN && eop_d) state_d = IDLE;
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_addr_q <= '0;
      len_q <= '0;
      issued_q <= '0;
      returned_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dout_en_q <= 1'b0;
      eop_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      cur_addr_q <= cur_addr_d;
      len_q <= len_d;
      issued_q <= issued_d;
      returned_q <= returned_d;
      ack_q <= ack_d;
      err_q <= err_d;
      dout_en_q <= dout_en_d;
      eop_q <= eop_d;
      dout_q <= dout_d;
    end
  end
endmodule

// File: tb/tb_dma_engineer.sv
// tb_dma_engineer: randomized memory model and transfer scoreboard for dma_engineer
module tb_dma_engineer;
  localparam int AW = 27, DW = 64, MO = 4;
  logic clk = 0, rst = 1;
  logic req = 0, ack, dout_en, eop, mem_rd_en, busy, err;
  logic [AW-1:0] req_addr = '0, req_len = '0, mem_rd_addr;
  logic [DW-1:0] dout, mem_rd_data = '0;
  logic mem_rd_rdy = 0, mem_rd_data_valid = 0;
  logic [31:0] salt;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, lat = 1, mode = 0, pat = 0;
  int n_ack = 0, ack_cyc = 0, n_acc = 0, first_acc = -1, last_acc = 0, n_beat = 0, n_eop = 0, eop_cyc = 0, fall_cyc = 0, peak = 0;
  logic busy_prev = 0;
  logic [AW-1:0] exp_addr[$], pq_addr[$];
  logic [DW-1:0] exp_data[$];
  bit exp_last[$];
  int pq_due[$];
  always #5 clk = ~clk;
  dma_engineer #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .dma_engineer_req(req), .dma_engineer_ack(ack),
    .dma_engineer_start_addr(req_addr), .dma_engineer_length(req_len),
    .dma_engineer_dout(dout), .dma_engineer_dout_en(dout_en), .dma_engineer_dout_eop(eop),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
    .mem_rd_data_valid(mem_rd_data_valid), .mem_rd_data(mem_rd_data),
    .busy(busy), .err_zero_len(err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {salt[9:0], a ^ salt[AW-1:0], a};
  endfunction
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  // memory model and scoreboard, evaluated mid-cycle once DUT outputs are stable
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pq_addr.delete(); pq_due.delete();
      exp_addr.delete(); exp_data.delete(); exp_last.delete();
      mem_rd_data_valid = 0;
      mem_rd_rdy = 0;
      busy_prev = 0;
    end else begin
      mem_rd_rdy = mode == 0 ? 1'b1 : mode == 1 ? (pat % 3 == 0) : 1'($urandom_range(0, 1));
      pat++;
      if (busy_prev && !busy) fall_cyc = cyc;
      busy_prev = busy;
      if (ack) begin
        n_ack++;
        ack_cyc = cyc;
        chk("err_zero_len", err, req_len == 0);
        for (int i = 0; i < int'(req_len); i++) begin
          logic [AW-1:0] a;
          a = req_addr + AW'(i);
          exp_addr.push_back(a);
          exp_data.push_back(mem_word(a));
          exp_last.push_back(i == int'(req_len) - 1);
        end
      end else if (err) chk("err_without_ack", 1, 0);
      if (pq_addr.size() > peak) peak = pq_addr.size();
      if (mem_rd_en && pq_addr.size() >= MO) chk("outstanding_cap", pq_addr.size(), MO - 1);
      if (pq_addr.size() != 0 && pq_due[0] <= cyc) begin
        mem_rd_data_valid = 1;
        mem_rd_data = mem_word(pq_addr.pop_front());
        void'(pq_due.pop_front());
      end else mem_rd_data_valid = 0;
      if (mem_rd_en && mem_rd_rdy) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        n_acc++;
        if (exp_addr.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", mem_rd_addr, exp_addr.pop_front());
        pq_addr.push_back(mem_rd_addr);
        pq_due.push_back(cyc + lat);
      end
      if (dout_en) begin
        n_beat++;
        if (exp_data.size() == 0) chk("dout_extra", 1, 0);
        else begin
          chk("dout", dout, exp_data.pop_front());
          chk("eop", eop, exp_last.pop_front());
        end
        if (eop) begin
          n_eop++;
          eop_cyc = cyc;
        end
      end else if (eop) chk("eop_without_en", 1, 0);
    end
  end
  task automatic clear_stats();
    n_acc = 0; n_beat = 0; n_eop = 0; peak = 0; first_acc = -1; pat = 0;
  endtask
  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] l, input int hold);
    int s, n0;
    req_addr = a;
    req_len = l;
    req = 1;
    s = cyc;
    n0 = n_ack;
    for (int i = 0; i < 50 && n_ack == n0; i++) step();
    chk("ack_seen", n_ack, n0 + 1);
    chk("ack_latency", ack_cyc - s, 1);
    repeat (hold) step();
    req = 0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 600 && (exp_data.size() != 0 || busy); i++) step();
    chk("drained", exp_data.size() == 0 && !busy, 1);
  endtask
  task automatic run(input logic [AW-1:0] a, input logic [AW-1:0] l, input int lt, input int md, input int hold);
    lat = lt;
    mode = md;
    clear_stats();
    issue(a, l, hold);
    if (l != 0) wait_done();
    chk("reads", n_acc, l);
    chk("beats", n_beat, l);
    chk("eops", n_eop, l != 0);
  endtask
  initial begin
    int n0;
    salt = $urandom;
    repeat (3) step();
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_dout_en", dout_en, 0);
    chk("rst_eop", eop, 0);
    chk("rst_err", err, 0);
    chk("rst_dout", dout, 0);
    rst = 0;
    step();
    run(1312, 8, 3, 0, 0);
    chk("basic_first_read_in_ack_cycle", first_acc, ack_cyc);
    chk("basic_consecutive_reads", last_acc - first_acc, 7);
    chk("basic_busy_fall", fall_cyc, eop_cyc + 1);
    run(100, 5, 2, 1, 0);
    run(4000, 12, 10, 0, 0);
    chk("cap_peak", peak, MO);
    n0 = n_ack;
    run(55, 0, 2, 0, 1);
    repeat (4) step();
    chk("zero_single_ack", n_ack, n0 + 1);
    chk("zero_no_reads", n_acc, 0);
    chk("zero_busy", busy, 0);
    run(27'h7FFFFFE, 4, 2, 0, 0);
    lat = 2;
    mode = 0;
    clear_stats();
    n0 = n_ack;
    req_addr = 500;
    req_len = 2;
    req = 1;
    for (int i = 0; i < 50 && n_ack == n0; i++) step();
    req_addr = 900;
    for (int i = 0; i < 50 && n_ack < n0 + 2; i++) step();
    chk("b2b_second_ack", n_ack, n0 + 2);
    chk("b2b_ack_after_eop", ack_cyc, eop_cyc + 1);
    req = 0;
    wait_done();
    chk("b2b_beats", n_beat, 4);
    chk("b2b_eops", n_eop, 2);
    clear_stats();
    issue(200, 8, 0);
    for (int i = 0; i < 100 && n_beat < 3; i++) step();
    rst = 1;
    step();
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", mem_rd_en, 0);
    chk("mid_rst_dout_en", dout_en, 0);
    chk("mid_rst_eop", eop, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_no_eop_seen", n_eop, 0);
    rst = 0;
    step();
    run(300, 6, 2, 0, 0);
    for (int k = 0; k < 5; k++)
      run(AW'($urandom), AW'($urandom_range(1, 20)), $urandom_range(1, 6), 2, $urandom_range(0, 1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
